// File: rtl/axi_bench_master.sv
// AXI4-Lite initiator that starts one router-bench session, polls STATUS until done,
// then reads back TCOND0..3 and WIN_ONEHOT into registered result outputs.
module axi_bench_master #(
    parameter int unsigned POLL_GAP   = 16,
    parameter int unsigned MAX_POLLS  = 65535,
    parameter logic [31:0] CTRL_WDATA = 32'h0000_0003
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_start,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic [31:0] t_cond0,
    output logic [31:0] t_cond1,
    output logic [31:0] t_cond2,
    output logic [31:0] t_cond3,
    output logic [3:0]  win_onehot,
    output logic [1:0]  winner_code,
    output logic [5:0]  m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [5:0]  m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    localparam logic [15:0] POLL_LIMIT = 16'(MAX_POLLS);
    localparam logic [15:0] GAP_LAST   = (POLL_GAP == 0) ? 16'd0 : 16'(POLL_GAP - 1);
    localparam bit          GAP_EN     = (POLL_GAP != 0);

    typedef enum logic [2:0] {S_IDLE, S_AW_W, S_B, S_AR, S_R, S_GAP, S_FIN} state_e;

    state_e      state_q, state_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic [1:0]  err_q, err_d, winner_q, winner_d;
    logic [31:0] tc0_q, tc0_d, tc1_q, tc1_d, tc2_q, tc2_d, tc3_q, tc3_d;
    logic [3:0]  win_q, win_d;
    logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic        arvalid_q, arvalid_d, rready_q, rready_d;
    logic [31:0] wdata_q, wdata_d;
    logic [5:0]  araddr_q, araddr_d;
    logic [15:0] poll_q, poll_d, gap_q, gap_d, poll_next;

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        winner_d  = winner_q;
        tc0_d     = tc0_q;
        tc1_d     = tc1_q;
        tc2_d     = tc2_q;
        tc3_d     = tc3_q;
        win_d     = win_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        wdata_d   = wdata_q;
        araddr_d  = araddr_q;
        poll_d    = poll_q;
        gap_d     = gap_q;
        poll_next = (poll_q == 16'hFFFF) ? poll_q : poll_q + 16'd1;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    busy_d    = 1'b1;
                    err_d     = 2'd0;
                    poll_d    = '0;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    wdata_d   = CTRL_WDATA;
                    state_d   = S_AW_W;
                end
            end
            S_AW_W: begin
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
                if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
                    bready_d = 1'b1;
                    state_d  = S_B;
                end
            end
            S_B: begin
                if (m_axi_bvalid && bready_q) begin
                    bready_d = 1'b0;
                    if (m_axi_bresp != 2'b00) begin
                        err_d   = 2'd1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_FIN;
                    end else begin
                        araddr_d  = 6'h04;
                        arvalid_d = 1'b1;
                        state_d   = S_AR;
                    end
                end
            end
            S_AR: begin
                if (arvalid_q && m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_R;
                end
            end
            S_R: begin
                if (m_axi_rvalid && rready_q) begin
                    rready_d = 1'b0;
                    if (m_axi_rresp != 2'b00) begin
                        err_d   = 2'd1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_FIN;
                    end else if (araddr_q == 6'h04) begin
                        poll_d = poll_next;
                        if (m_axi_rdata[1]) begin
                            winner_d  = m_axi_rdata[3:2];
                            araddr_d  = 6'h08;
                            arvalid_d = 1'b1;
                            state_d   = S_AR;
                        end else if (poll_next >= POLL_LIMIT) begin
                            err_d   = 2'd2;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_FIN;
                        end else if (GAP_EN) begin
                            gap_d   = '0;
                            state_d = S_GAP;
                        end else begin
                            arvalid_d = 1'b1;
                            state_d   = S_AR;
                        end
                    end else begin
                        // Readback walks 0x08..0x18; the final WIN_ONEHOT read ends the session.
                        case (araddr_q)
                            6'h08:   tc0_d = m_axi_rdata;
                            6'h0C:   tc1_d = m_axi_rdata;
                            6'h10:   tc2_d = m_axi_rdata;
                            6'h14:   tc3_d = m_axi_rdata;
                            default: win_d = m_axi_rdata[3:0];
                        endcase
                        if (araddr_q >= 6'h18) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_FIN;
                        end else begin
                            araddr_d  = araddr_q + 6'h04;
                            arvalid_d = 1'b1;
                            state_d   = S_AR;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    araddr_d  = 6'h04;
                    arvalid_d = 1'b1;
                    state_d   = S_AR;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= '0;
            winner_q  <= '0;
            tc0_q     <= '0;
            tc1_q     <= '0;
            tc2_q     <= '0;
            tc3_q     <= '0;
            win_q     <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            wdata_q   <= '0;
            araddr_q  <= '0;
            poll_q    <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            winner_q  <= winner_d;
            tc0_q     <= tc0_d;
            tc1_q     <= tc1_d;
            tc2_q     <= tc2_d;
            tc3_q     <= tc3_d;
            win_q     <= win_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            wdata_q   <= wdata_d;
            araddr_q  <= araddr_d;
            poll_q    <= poll_d;
            gap_q     <= gap_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign t_cond0       = tc0_q;
    assign t_cond1       = tc1_q;
    assign t_cond2       = tc2_q;
    assign t_cond3       = tc3_q;
    assign win_onehot    = win_q;
    assign winner_code   = winner_q;
    assign m_axi_awaddr  = 6'h00;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_bench_master.sv
// Bench for axi_bench_master: AXI4-Lite slave model with configurable ready skew,
// STATUS done timing and error injection; expected read sequence and results are modelled here.
module tb_axi_bench_master;

    localparam int unsigned GAP  = 4;
    localparam int unsigned MAXP = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_start;
    logic        busy, done;
    logic [1:0]  err, winner_code;
    logic [31:0] t_cond0, t_cond1, t_cond2, t_cond3;
    logic [3:0]  win_onehot;
    logic [5:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;

    always #5 clk = ~clk;

    axi_bench_master #(
        .POLL_GAP  (GAP),
        .MAX_POLLS (MAXP),
        .CTRL_WDATA(32'h0000_0003)
    ) dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .busy(busy), .done(done), .err(err),
        .t_cond0(t_cond0), .t_cond1(t_cond1), .t_cond2(t_cond2), .t_cond3(t_cond3),
        .win_onehot(win_onehot), .winner_code(winner_code),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    // Slave configuration (written by the stimulus process only)
    int          cfg_aw_dly, cfg_w_dly, cfg_done_after;
    logic [1:0]  cfg_bresp, cfg_winner;
    logic [5:0]  cfg_err_addr;
    logic [31:0] cfg_reg [5];

    // Slave state and monotonic observation counters (written by the slave process only)
    int          aw_cnt, w_cnt, st_reads;
    bit          aw_got, w_got;
    int          aw_hs = 0, w_hs = 0, b_hs = 0, skew_cyc = 0, done_cnt = 0;
    logic [5:0]  aw_log;
    logic [31:0] wd_log;
    logic [5:0]  rd_q [$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; arready <= 1'b0; rvalid <= 1'b0;
            bresp <= '0; rresp <= '0; rdata <= '0;
            aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
        end else begin
            if (awvalid && !awready) begin
                if (aw_cnt >= cfg_aw_dly) awready <= 1'b1; else aw_cnt <= aw_cnt + 1;
            end
            if (awvalid && awready) begin
                awready <= 1'b0; aw_cnt <= 0; aw_got <= 1'b1;
                aw_hs <= aw_hs + 1; aw_log <= awaddr; st_reads <= 0;
            end
            if (wvalid && !wready) begin
                if (w_cnt >= cfg_w_dly) wready <= 1'b1; else w_cnt <= w_cnt + 1;
            end
            if (wvalid && wready) begin
                wready <= 1'b0; w_cnt <= 0; w_got <= 1'b1;
                w_hs <= w_hs + 1; wd_log <= wdata;
            end
            if (aw_got && w_got && !bvalid) begin
                bvalid <= 1'b1; bresp <= cfg_bresp; aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0; b_hs <= b_hs + 1;
            end
            if (!awvalid && wvalid) skew_cyc <= skew_cyc + 1;
            if (arvalid && !arready && !rvalid) arready <= 1'b1;
            if (arvalid && arready) begin
                arready <= 1'b0;
                rd_q.push_back(araddr);
                rvalid <= 1'b1;
                rresp  <= (araddr == cfg_err_addr) ? 2'b10 : 2'b00;
                case (araddr)
                    6'h04: begin
                        st_reads <= st_reads + 1;
                        if (cfg_done_after != 0 && st_reads + 1 >= cfg_done_after)
                            rdata <= {28'h0, cfg_winner, 2'b10};
                        else
                            rdata <= '0;
                    end
                    6'h08:   rdata <= cfg_reg[0];
                    6'h0C:   rdata <= cfg_reg[1];
                    6'h10:   rdata <= cfg_reg[2];
                    6'h14:   rdata <= cfg_reg[3];
                    6'h18:   rdata <= cfg_reg[4];
                    default: rdata <= 32'hDEAD_BEEF;
                endcase
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         aw_dly;
        int         w_dly;
        int         done_after;
        logic [1:0] bresp;
        logic [5:0] err_addr;
    } vec_t;

    logic [31:0] m_tc [4];
    logic [3:0]  m_win;
    logic [1:0]  m_winner;

    task automatic run_session(input int sid, input vec_t v, input bit retrigger);
        logic [5:0] exp_q [$];
        logic [1:0] exp_err;
        int n, c, aw0, w0, b0, sk0, rd0, dn0;
        bit st_done;

        cfg_aw_dly = v.aw_dly; cfg_w_dly = v.w_dly; cfg_done_after = v.done_after;
        cfg_bresp = v.bresp; cfg_err_addr = v.err_addr;
        for (int i = 0; i < 5; i++) cfg_reg[i] = $urandom;
        cfg_winner = 2'($urandom_range(0, 3));

        // Expected read sequence and result fields
        exp_err = 2'd0; n = 0; st_done = 1'b0;
        if (v.bresp != 2'b00) exp_err = 2'd1;
        while (exp_err == 2'd0 && !st_done) begin
            n++;
            exp_q.push_back(6'h04);
            if (v.err_addr == 6'h04) exp_err = 2'd1;
            else if (v.done_after != 0 && n >= v.done_after) st_done = 1'b1;
            else if (n >= int'(MAXP)) exp_err = 2'd2;
        end
        if (st_done) begin
            m_winner = cfg_winner;
            for (int a = 8; a <= 24 && exp_err == 2'd0; a += 4) begin
                exp_q.push_back(6'(a));
                if (v.err_addr == 6'(a)) exp_err = 2'd1;
                else if (a == 24) m_win = cfg_reg[4][3:0];
                else m_tc[(a - 8) / 4] = cfg_reg[(a - 8) / 4];
            end
        end

        aw0 = aw_hs; w0 = w_hs; b0 = b_hs; sk0 = skew_cyc; rd0 = rd_q.size(); dn0 = done_cnt;
        @(negedge clk) cmd_start = 1'b1;
        @(negedge clk) cmd_start = 1'b0;
        check($sformatf("s%0d_busy_after_start", sid), busy, 1);
        check($sformatf("s%0d_err_cleared", sid), err, 0);

        c = 0;
        while (done !== 1'b1 && c < 400) begin
            @(negedge clk);
            c++;
            cmd_start = retrigger && (c == 12);
        end
        cmd_start = 1'b0;
        check($sformatf("s%0d_done_seen", sid), done, 1);
        check($sformatf("s%0d_busy_at_done", sid), busy, 0);
        check($sformatf("s%0d_err", sid), err, exp_err);
        check($sformatf("s%0d_t_cond0", sid), t_cond0, m_tc[0]);
        check($sformatf("s%0d_t_cond1", sid), t_cond1, m_tc[1]);
        check($sformatf("s%0d_t_cond2", sid), t_cond2, m_tc[2]);
        check($sformatf("s%0d_t_cond3", sid), t_cond3, m_tc[3]);
        check($sformatf("s%0d_win_onehot", sid), win_onehot, m_win);
        check($sformatf("s%0d_winner_code", sid), winner_code, m_winner);
        @(negedge clk);
        check($sformatf("s%0d_done_one_cycle", sid), done, 0);
        repeat (30) @(negedge clk);

        check($sformatf("s%0d_done_pulses", sid), done_cnt - dn0, 1);
        check($sformatf("s%0d_aw_count", sid), aw_hs - aw0, 1);
        check($sformatf("s%0d_w_count", sid), w_hs - w0, 1);
        check($sformatf("s%0d_b_count", sid), b_hs - b0, 1);
        check($sformatf("s%0d_awaddr", sid), aw_log, 6'h00);
        check($sformatf("s%0d_wdata", sid), wd_log, 32'h3);
        if (v.w_dly > v.aw_dly)
            check($sformatf("s%0d_aw_drops_first", sid), skew_cyc - sk0 > 0, 1);
        check($sformatf("s%0d_read_count", sid), rd_q.size() - rd0, exp_q.size());
        for (int i = 0; i < exp_q.size() && rd0 + i < rd_q.size(); i++)
            check($sformatf("s%0d_read%0d_addr", sid, i), rd_q[rd0 + i], exp_q[i]);
    endtask

    vec_t tbl [9];
    vec_t nominal;
    int   c;

    initial begin
        tbl[0] = '{0, 0, 3, 2'b00, 6'h3F};   // nominal, 3 polls
        tbl[1] = '{0, 5, 1, 2'b00, 6'h3F};   // awready well ahead of wready
        tbl[2] = '{0, 0, 2, 2'b00, 6'h0C};   // SLVERR on TCOND1
        tbl[3] = '{0, 0, 0, 2'b00, 6'h3F};   // STATUS never done
        tbl[4] = '{0, 0, 3, 2'b00, 6'h3F};   // rerun after timeout
        tbl[5] = '{0, 0, 1, 2'b10, 6'h3F};   // BRESP error
        tbl[6] = '{0, 0, 2, 2'b00, 6'h04};   // RRESP error on STATUS
        tbl[7] = '{5, 0, 3, 2'b00, 6'h18};   // wready ahead, error on WIN_ONEHOT
        tbl[8] = '{2, 3, 4, 2'b00, 6'h3F};   // done would come after MAX_POLLS
        nominal = tbl[0];

        for (int i = 0; i < 4; i++) m_tc[i] = '0;
        m_win = '0; m_winner = '0;
        cfg_aw_dly = 0; cfg_w_dly = 0; cfg_done_after = 1; cfg_bresp = '0;
        cfg_err_addr = 6'h3F; cfg_winner = '0;
        for (int i = 0; i < 5; i++) cfg_reg[i] = '0;

        cmd_start = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_valids", {awvalid, wvalid, arvalid}, 0);
        check("rst_readies", {bready, rready}, 0);
        check("rst_results", t_cond0 | t_cond1 | t_cond2 | t_cond3, 0);
        check("rst_win_winner", {win_onehot, winner_code}, 0);
        check("rst_addrs", {awaddr, araddr}, 0);
        check("rst_wdata", wdata, 0);
        check("rst_wstrb", wstrb, 4'hF);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) run_session(i, tbl[i], 1'b0);

        // cmd_start pulsed mid-poll must not restart or queue a session
        run_session(20, nominal, 1'b1);

        // Asynchronous reset while a read address is pending
        @(negedge clk) cmd_start = 1'b1;
        @(negedge clk) cmd_start = 1'b0;
        c = 0;
        while (arvalid !== 1'b1 && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("rst_mid_arvalid_seen", arvalid, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_arvalid", arvalid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_err", err, 0);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 4; i++) m_tc[i] = '0;
        m_win = '0; m_winner = '0;
        repeat (2) @(negedge clk);
        run_session(21, nominal, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
